// File: rtl/fp_to_fixed_pipe_if.sv
// Valid/ready bundle for fp_to_fixed_pipe: binary32 samples in, fixed-point results and flags out.
interface fp_to_fixed_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_fp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_fix;
  logic [2:0]  out_flags;

  modport master (
    output in_valid, in_fp, out_ready,
    input  in_ready, out_valid, out_fix, out_flags
  );

  modport slave (
    input  in_valid, in_fp, out_ready,
    output in_ready, out_valid, out_fix, out_flags
  );
endinterface

// File: rtl/fp_to_fixed_pipe.sv
// Two-stage binary32 to signed fixed-point converter, out_flags = {nan, ovf, inexact}.
// Define ROUND_NEAREST_EN for round-to-nearest-even; otherwise the magnitude truncates toward zero.
module fp_to_fixed_pipe #(
  parameter int FRAC_BITS = 0
) (
  input  logic             clk,
  input  logic             rst,
  fp_to_fixed_pipe_if.slave bus
);

  localparam logic signed [9:0] FRAC_S = 10'(FRAC_BITS);

  logic               s1_valid, s2_valid;
  logic               s1_en, s2_en;
  logic               s1_sign, s1_nan, s1_inf, s1_zero, s1_den;
  logic [23:0]        s1_mant;
  logic signed [9:0]  s1_shift;
  logic [31:0]        fix_q;
  logic [2:0]         flags_q;
  logic [7:0]         in_exp;
  logic [22:0]        in_frac;

  assign in_exp  = bus.in_fp[30:23];
  assign in_frac = bus.in_fp[22:0];

  assign s2_en         = !s2_valid || bus.out_ready;
  assign s1_en         = !s1_valid || s2_en;
  assign bus.in_ready  = !rst && s1_en;
  assign bus.out_valid = s2_valid;
  assign bus.out_fix   = fix_q;
  assign bus.out_flags = flags_q;

  // stage 1: unpack and compute the scaling shift
  always_ff @(posedge clk) begin
    if (s1_en && bus.in_valid) begin
      s1_sign  <= bus.in_fp[31];
      s1_mant  <= {(in_exp != 8'd0), in_frac};
      s1_shift <= $signed({2'b00, in_exp}) - 10'sd127 + FRAC_S;
      s1_nan   <= (in_exp == 8'hFF) && (in_frac != 23'd0);
      s1_inf   <= (in_exp == 8'hFF) && (in_frac == 23'd0);
      s1_zero  <= (in_exp == 8'h00) && (in_frac == 23'd0);
      s1_den   <= (in_exp == 8'h00) && (in_frac != 23'd0);
    end
  end

  logic signed [9:0] r_sh;
  logic [5:0]        rsh;
  logic [3:0]        lsh;
  logic [49:0]       wide;
  logic [32:0]       mag, mag_rnd;
  logic              guard, sticky, big, rng_ovf;
  logic [31:0]       sat_val, fix_n;
  logic [2:0]        flags_n;

  always_comb begin
    r_sh   = '0;
    rsh    = '0;
    lsh    = '0;
    wide   = '0;
    mag    = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    big    = s1_shift > 10'sd31;
    if (s1_shift >= 10'sd23) begin
      lsh = 4'(s1_shift - 10'sd23);
      mag = {9'd0, s1_mant} << lsh;
    end else begin
      // beyond 26 places every mantissa bit lands in sticky, so clamp the shifter
      r_sh   = 10'sd23 - s1_shift;
      rsh    = (r_sh > 10'sd26) ? 6'd26 : 6'(r_sh);
      wide   = {s1_mant, 26'd0} >> rsh;
      mag    = {9'd0, wide[49:26]};
      guard  = wide[25];
      sticky = |wide[24:0];
    end
`ifdef ROUND_NEAREST_EN
    mag_rnd = mag + {32'd0, guard & (sticky | mag[0])};
`else
    mag_rnd = mag;
`endif
    // -2^31 is representable, so the negative limit is one larger
    rng_ovf = big || (s1_sign ? (mag_rnd > 33'h0_8000_0000) : (mag_rnd > 33'h0_7FFF_FFFF));
    sat_val = s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    fix_n   = '0;
    flags_n = '0;
    if (s1_nan) begin
      flags_n = 3'b100;
    end else if (s1_inf) begin
      fix_n   = sat_val;
      flags_n = 3'b010;
    end else if (s1_zero) begin
      flags_n = 3'b000;
    end else if (s1_den) begin
      flags_n = 3'b001;
    end else if (rng_ovf) begin
      fix_n   = sat_val;
      flags_n = 3'b010;
    end else begin
      fix_n   = s1_sign ? (~mag_rnd[31:0] + 32'd1) : mag_rnd[31:0];
      flags_n = {2'b00, guard | sticky};
    end
  end

  // stage 2: registered result, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      fix_q    <= '0;
      flags_q  <= '0;
    end else begin
      if (s1_en) s1_valid <= bus.in_valid;
      if (s2_en) s2_valid <= s1_valid;
      if (s2_en && s1_valid) begin
        fix_q   <= fix_n;
        flags_q <= flags_n;
      end
    end
  end

endmodule

// File: tb/tb_fp_to_fixed_pipe.sv
// Directed bench for fp_to_fixed_pipe: FRAC_BITS=0 and FRAC_BITS=16 instances share one stimulus stream.
module tb_fp_to_fixed_pipe;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fp_to_fixed_pipe_if if0();
  fp_to_fixed_pipe_if if16();

  assign if16.in_valid  = if0.in_valid;
  assign if16.in_fp     = if0.in_fp;
  assign if16.out_ready = if0.out_ready;

  fp_to_fixed_pipe #(.FRAC_BITS(0))  dut0  (.clk(clk), .rst(rst), .bus(if0.slave));
  fp_to_fixed_pipe #(.FRAC_BITS(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

`ifdef ROUND_NEAREST_EN
  localparam logic [31:0] E_M35 = 32'hFFFF_FFFC;
  localparam logic [31:0] E_P15 = 32'h0000_0002;
  localparam logic [31:0] E_P075 = 32'h0000_0001;
`else
  localparam logic [31:0] E_M35 = 32'hFFFF_FFFD;
  localparam logic [31:0] E_P15 = 32'h0000_0001;
  localparam logic [31:0] E_P075 = 32'h0000_0000;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one sample: accepted on the first edge, result visible after the second edge
  task automatic run_vec(input string tag, input logic [31:0] fp,
                         input logic [31:0] e0, input logic [2:0] f0,
                         input logic [31:0] e16, input logic [2:0] f16);
    @(negedge clk);
    if0.in_valid  = 1'b1;
    if0.in_fp     = fp;
    if0.out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, {31'd0, if0.in_ready}, 32'd1);
    chk({tag, " in_ready16"}, {31'd0, if16.in_ready}, 32'd1);
    @(negedge clk);
    if0.in_valid = 1'b0;
    #1;
    chk({tag, " early valid"}, {31'd0, if0.out_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk({tag, " valid"}, {31'd0, if0.out_valid}, 32'd1);
    chk({tag, " fix"}, if0.out_fix, e0);
    chk({tag, " flags"}, {29'd0, if0.out_flags}, {29'd0, f0});
    chk({tag, " valid16"}, {31'd0, if16.out_valid}, 32'd1);
    chk({tag, " fix16"}, if16.out_fix, e16);
    chk({tag, " flags16"}, {29'd0, if16.out_flags}, {29'd0, f16});
  endtask

  logic [31:0] bp_in [6];
  int          sent, got;
  logic        saw_block, prev_stall;
  logic [31:0] prev_fix;

  initial begin
    rst = 1'b1;
    if0.in_valid  = 1'b0;
    if0.in_fp     = 32'd0;
    if0.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset in_ready", {31'd0, if0.in_ready}, 32'd0);
    chk("reset out_valid", {31'd0, if0.out_valid}, 32'd0);
    chk("reset out_fix", if0.out_fix, 32'd0);
    chk("reset out_flags", {29'd0, if0.out_flags}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post reset in_ready", {31'd0, if0.in_ready}, 32'd1);

    //       tag        input          FRAC 0 fix     flags   FRAC 16 fix    flags
    run_vec("pi",      32'h40490FDB, 32'h0000_0003, 3'b001, 32'h0003_243F, 3'b001);
    run_vec("m3p5",    32'hC0600000, E_M35,         3'b001, 32'hFFFC_8000, 3'b000);
    run_vec("m2p5",    32'hC0200000, 32'hFFFF_FFFE, 3'b001, 32'hFFFD_8000, 3'b000);
    run_vec("p1p5",    32'h3FC00000, E_P15,         3'b001, 32'h0001_8000, 3'b000);
    run_vec("p0p75",   32'h3F400000, E_P075,        3'b001, 32'h0000_C000, 3'b000);
    run_vec("p2m24",   32'h33800000, 32'h0000_0000, 3'b001, 32'h0000_0000, 3'b001);
    run_vec("tiny",    32'h30000000, 32'h0000_0000, 3'b001, 32'h0000_0000, 3'b001);
    run_vec("p100",    32'h42C80000, 32'h0000_0064, 3'b000, 32'h0064_0000, 3'b000);
    run_vec("m1",      32'hBF800000, 32'hFFFF_FFFF, 3'b000, 32'hFFFF_0000, 3'b000);
    run_vec("p2e31",   32'h4F000000, 32'h7FFF_FFFF, 3'b010, 32'h7FFF_FFFF, 3'b010);
    run_vec("m2e31",   32'hCF000000, 32'h8000_0000, 3'b000, 32'h8000_0000, 3'b010);
    run_vec("m2e31p",  32'hCF000001, 32'h8000_0000, 3'b010, 32'h8000_0000, 3'b010);
    run_vec("maxpos",  32'h4EFFFFFF, 32'h7FFF_FF80, 3'b000, 32'h7FFF_FFFF, 3'b010);
    run_vec("maxneg",  32'hCEFFFFFF, 32'h8000_0080, 3'b000, 32'h8000_0000, 3'b010);
    run_vec("p2e15",   32'h47000000, 32'h0000_8000, 3'b000, 32'h7FFF_FFFF, 3'b010);
    run_vec("m2e15",   32'hC7000000, 32'hFFFF_8000, 3'b000, 32'h8000_0000, 3'b000);
    run_vec("ninf",    32'hFF800000, 32'h8000_0000, 3'b010, 32'h8000_0000, 3'b010);
    run_vec("pinf",    32'h7F800000, 32'h7FFF_FFFF, 3'b010, 32'h7FFF_FFFF, 3'b010);
    run_vec("nan",     32'h7FC00000, 32'h0000_0000, 3'b100, 32'h0000_0000, 3'b100);
    run_vec("zero",    32'h00000000, 32'h0000_0000, 3'b000, 32'h0000_0000, 3'b000);
    run_vec("denorm",  32'h00000001, 32'h0000_0000, 3'b001, 32'h0000_0000, 3'b001);

    // back-to-back 1.0 .. 6.0 with the consumer stalled in cycles 3-6
    bp_in = '{32'h3F800000, 32'h40000000, 32'h40400000,
              32'h40800000, 32'h40A00000, 32'h40C00000};
    sent = 0;
    got = 0;
    saw_block = 1'b0;
    prev_stall = 1'b0;
    prev_fix = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if0.out_ready = !(c >= 3 && c <= 6);
      if (sent < 6) begin
        if0.in_valid = 1'b1;
        if0.in_fp    = bp_in[sent];
      end else begin
        if0.in_valid = 1'b0;
        if0.in_fp    = 32'd0;
      end
      #1;
      if (prev_stall) begin
        chk("bp hold valid", {31'd0, if0.out_valid}, 32'd1);
        chk("bp hold fix", if0.out_fix, prev_fix);
      end
      if (sent < 6 && !if0.in_ready) saw_block = 1'b1;
      if (if0.out_valid && if0.out_ready) begin
        chk("bp order", if0.out_fix, 32'(got + 1));
        got++;
      end
      prev_stall = if0.out_valid && !if0.out_ready;
      prev_fix   = if0.out_fix;
      if (if0.in_valid && if0.in_ready) sent++;
    end
    chk("bp in_ready fell", {31'd0, saw_block}, 32'd1);
    chk("bp sent", 32'(sent), 32'd6);
    chk("bp received", 32'(got), 32'd6);

    // reset with two samples in flight
    @(negedge clk);
    if0.out_ready = 1'b0;
    if0.in_valid  = 1'b1;
    if0.in_fp     = 32'h40000000;
    @(negedge clk);
    if0.in_fp = 32'h40400000;
    @(negedge clk);
    if0.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst inflight valid", {31'd0, if0.out_valid}, 32'd1);
    chk("rst in_ready low", {31'd0, if0.in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    if0.out_ready = 1'b1;
    #1;
    chk("rst out_valid cleared", {31'd0, if0.out_valid}, 32'd0);
    chk("rst out_fix cleared", if0.out_fix, 32'd0);
    chk("rst in_ready after", {31'd0, if0.in_ready}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("rst no stale", {31'd0, if0.out_valid}, 32'd0);
      chk("rst no stale16", {31'd0, if16.out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_to_fixed_pipe.md
FP_TO_FIXED_PIPE -- requirements
Module: fp_to_fixed_pipe

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 0, range 0..16: number of fraction bits in the output word; output equals the input value times 2^FRAC_BITS.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_fp holds a valid sample.
REQ-005 SHALL have port in_ready  output  1  block accepts in_fp this cycle.
REQ-006 SHALL have port in_fp  input  32  IEEE-754 binary32 value, for example an orbit X/Y coordinate.
REQ-007 SHALL have port out_valid  output  1  out_fix and out_flags are valid.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the output this cycle.
REQ-009 SHALL have port out_fix  output  32  signed two's-complement fixed-point result.
REQ-010 SHALL have port out_flags  output  3  {nan, ovf, inexact}.

Function
REQ-011 SHALL transfer an input when in_valid and in_ready are both high on a rising edge, and an output when out_valid and out_ready are both high on a rising edge.
REQ-012 SHALL be a 2-stage pipeline: stage 1 unpacks the value and computes the shift s = exp - 127 + FRAC_BITS; stage 2 shifts, rounds, negates, saturates and registers the result.
REQ-013 SHALL assert out_valid exactly 2 cycles after the accepting edge when the pipeline is not stalled, and SHALL sustain 1 result per cycle.
REQ-014 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready; each stage advances when the stage downstream of it is empty or is being drained.
REQ-015 SHALL preserve input order, and SHALL never drop or duplicate a sample under any out_ready pattern.
REQ-016 SHALL hold out_fix, out_flags and out_valid stable while out_valid=1 and out_ready=0.
REQ-017 SHALL round toward zero by default: the magnitude keeps only its integer part after scaling.
REQ-018 SHALL set inexact=1 when any nonzero bit is discarded by the shift or rounding.
REQ-019 SHALL handle zero (exp=0, mantissa=0) as out_fix=0 with all flags 0.
REQ-020 SHALL handle a denormal as out_fix=0 with inexact=1.
REQ-021 SHALL handle NaN (exp=255, mantissa!=0) as out_fix=0 with nan=1.
REQ-022 SHALL handle Inf as out_fix=0x7FFFFFFF (sign 0) or 0x80000000 (sign 1) with ovf=1.
REQ-023 SHALL saturate when s>=31 or when the rounded magnitude exceeds the range: 0x7FFFFFFF with ovf=1 for a positive value, 0x80000000 with ovf=1 for a negative value.
REQ-024 SHALL return the exact value -2^31 (sign=1, s=31, mantissa=0) as 0x80000000 with ovf=0.
REQ-025 SHALL produce a magnitude of 0 when s < -25 (1 when rounding up applies), with inexact=1.
REQ-026 SHALL leave inexact=0 whenever ovf=1 or nan=1.

Reset
REQ-027 SHALL, while rst=1, clear both stage valid bits, drive out_valid=0, out_fix=0 and out_flags=0, and hold in_ready=0.
REQ-028 SHALL discard in-flight samples when rst asserts mid-operation, and SHALL produce no output for them after reset is released.
REQ-029 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL round to nearest, ties to even, when ROUND_NEAREST_EN is defined: it uses the guard and sticky bits, may carry into saturation (setting ovf=1), and sets inexact on any discarded nonzero bits.
REQ-031 SHALL round toward zero exactly as in REQ-017, and SHALL contain no rounding incrementer, when ROUND_NEAREST_EN is not defined.

Verification
REQ-032 SHALL cover, with FRAC_BITS=0: 0x40490FDB (pi) -> 0x00000003 with inexact=1; 0xC0600000 (-3.5) -> 0xFFFFFFFD (RTZ) or 0xFFFFFFFC (RNE); 0xC0200000 (-2.5) -> 0xFFFFFFFE in both modes, inexact=1.
REQ-033 SHALL cover saturation and the exact minimum: 0x4F000000 -> 0x7FFFFFFF with ovf=1; 0xCF000000 -> 0x80000000 with flags 0; 0xFF800000 -> 0x80000000 with ovf=1; 0x7FC00000 -> 0 with nan=1.
REQ-034 SHALL cover fixed-point scaling with FRAC_BITS=16: 0x3FC00000 (1.5) -> 0x00018000 with flags 0; 0x33800000 (2^-24) -> 0 with inexact=1.
REQ-035 SHALL cover throughput and backpressure: issue 6 back-to-back inputs with out_ready held 0 for cycles 3-6. Required: in_ready falls once both stages are full, all 6 results arrive in order, and outputs stay stable while stalled.
REQ-036 SHALL cover reset mid-stream: pulse rst for 1 cycle with 2 samples in flight. Required: out_valid=0 in the next cycle, no stale output appears, and in_ready=1 in the first cycle after rst deasserts.
